// File: rtl/bch_frame_sequencer.sv
// Byte sequencer driving the BCH channel stages: encode -> noise -> decode.
// Optional per-stage watchdog is enabled by defining SEQ_TIMEOUT_EN.
module bch_frame_sequencer #(
   parameter int DATA_W      = 8,
   parameter int CW_W        = 16,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_bch,
   input  logic              cfg_fs,
   input  logic              cfg_gauss,
   input  logic              cfg_ber,
   output logic [1:0]        noise_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              enc_start,
   output logic [DATA_W-1:0] enc_din,
   input  logic              enc_done,
   input  logic [CW_W-1:0]   enc_dout,
   output logic              noise_start,
   output logic [CW_W-1:0]   noise_din,
   input  logic              noise_done,
   input  logic [CW_W-1:0]   noise_dout,
   output logic              dec_start,
   output logic [CW_W-1:0]   dec_din,
   input  logic              dec_done,
   input  logic [DATA_W-1:0] dec_dout,
   input  logic              dec_uncorr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   input  logic              abort,
   input  logic              clr_cnt,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              timeout_flag
);

`ifdef SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, ENC, NOISE, DEC, OUT} state_t;

   state_t            state_q, state_d;
   logic              first_q;
   logic              bch_q;
   logic [1:0]        mode_q, mode_in;
   logic [DATA_W-1:0] data_q;
   logic [CW_W-1:0]   word_q;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic              oerr_q, oerr_d;
   logic [TW-1:0]     tmo_q;
   logic              tmo_hit, tflag_q;
   logic              in_stage, done_ok, hs_in, hs_out;
   logic [CNT_W-1:0]  fcnt_q, ecnt_q;

   // Gauss > BER > FS
   assign mode_in = cfg_gauss ? 2'd2 :
                    cfg_ber   ? 2'd3 :
                    cfg_fs    ? 2'd1 : 2'd0;

   assign in_stage = (state_q == ENC) || (state_q == NOISE) ||
                     (state_q == DEC);
   assign in_ready = (state_q == IDLE) && !abort;
   assign hs_in    = in_valid && in_ready;
   assign out_valid = (state_q == OUT) && !abort;
   assign hs_out   = out_valid && out_ready;

   assign enc_start   = (state_q == ENC) && first_q;
   assign noise_start = (state_q == NOISE) && first_q;
   assign dec_start   = (state_q == DEC) && first_q;
   assign enc_din     = data_q;
   assign noise_din   = word_q;
   assign dec_din     = word_q;

   assign noise_mode   = mode_q;
   assign out_data     = odata_q;
   assign out_err      = oerr_q;
   assign busy         = (state_q != IDLE);
   assign frame_cnt    = fcnt_q;
   assign err_cnt      = ecnt_q;
   assign timeout_flag = tflag_q;

   // A done coincident with start is not a response to this start
   always_comb begin
      done_ok = 1'b0;
      unique case (state_q)
         ENC:     done_ok = enc_done;
         NOISE:   done_ok = noise_done;
         DEC:     done_ok = dec_done;
         default: done_ok = 1'b0;
      endcase
      done_ok = done_ok && !first_q;
   end

   assign tmo_hit = TMO_EN && in_stage && !done_ok &&
                    (tmo_q == TW'(TIMEOUT_CYC));

   always_comb begin
      state_d = state_q;
      odata_d = odata_q;
      oerr_d  = oerr_q;
      unique case (state_q)
         IDLE: if (hs_in) begin
            state_d = cfg_bch          ? ENC   :
                      (mode_in != 2'd0) ? NOISE : OUT;
            odata_d = in_data;
            oerr_d  = 1'b0;
         end
         ENC: if (done_ok)
            state_d = (mode_q != 2'd0) ? NOISE : DEC;
         NOISE: if (done_ok) begin
            state_d = bch_q ? DEC : OUT;
            odata_d = DATA_W'(noise_dout);
            oerr_d  = 1'b0;
         end
         DEC: if (done_ok) begin
            state_d = OUT;
            odata_d = dec_dout;
            oerr_d  = dec_uncorr;
         end
         OUT: if (hs_out)
            state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo_hit) begin
         state_d = OUT;
         odata_d = '0;
         oerr_d  = 1'b1;
      end
      if (abort && state_q != IDLE)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         bch_q   <= 1'b0;
         mode_q  <= 2'd0;
         data_q  <= '0;
         word_q  <= '0;
         odata_q <= '0;
         oerr_q  <= 1'b0;
         tmo_q   <= '0;
         tflag_q <= 1'b0;
         fcnt_q  <= '0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         odata_q <= odata_d;
         oerr_q  <= oerr_d;
         first_q <= (state_d != state_q) &&
                    (state_d inside {ENC, NOISE, DEC});
         if (state_d != state_q)
            tmo_q <= '0;
         else if (in_stage)
            tmo_q <= tmo_q + 1'b1;
         if (hs_in) begin
            data_q <= in_data;
            word_q <= CW_W'(in_data);
            bch_q  <= cfg_bch;
            mode_q <= mode_in;
         end else if (done_ok && state_q == ENC) begin
            word_q <= enc_dout;
         end else if (done_ok && state_q == NOISE) begin
            word_q <= noise_dout;
         end
         if (clr_cnt)
            tflag_q <= 1'b0;
         else if (tmo_hit)
            tflag_q <= 1'b1;
         if (clr_cnt)
            fcnt_q <= '0;
         else if (hs_out && fcnt_q != '1)
            fcnt_q <= fcnt_q + 1'b1;
         if (clr_cnt)
            ecnt_q <= '0;
         else if (hs_out && oerr_q && ecnt_q != '1)
            ecnt_q <= ecnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_bch_frame_sequencer.sv
// Bench for bch_frame_sequencer: stage responders, latency/result model,
// per-cycle compare plus literal pins. Define SEQ_TIMEOUT_EN for the watchdog case.
module tb_bch_frame_sequencer;
   localparam int DW  = 8;
   localparam int CW  = 16;
   localparam int CN  = 4;
   localparam int TMO = 4;
   localparam int SAT = (1 << CN) - 1;
`ifdef SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfg_bch = 0, cfg_fs = 0, cfg_gauss = 0, cfg_ber = 0;
   logic [1:0] noise_mode;
   logic in_valid = 0, in_ready;
   logic [DW-1:0] in_data = '0;
   logic enc_start, noise_start, dec_start;
   logic [DW-1:0] enc_din;
   logic [CW-1:0] noise_din, dec_din;
   logic enc_done = 0, noise_done = 0, dec_done = 0, dec_uncorr = 0;
   logic [CW-1:0] enc_dout = '0, noise_dout = '0;
   logic [DW-1:0] dec_dout = '0;
   logic out_valid, out_ready = 1, out_err;
   logic [DW-1:0] out_data;
   logic abort = 0, clr_cnt = 0, busy, timeout_flag;
   logic [CN-1:0] frame_cnt, err_cnt;

   always #5 clk = ~clk;

   bch_frame_sequencer #(
      .DATA_W(DW), .CW_W(CW), .CNT_W(CN), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_bch(cfg_bch), .cfg_fs(cfg_fs), .cfg_gauss(cfg_gauss),
      .cfg_ber(cfg_ber), .noise_mode(noise_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .enc_start(enc_start), .enc_din(enc_din), .enc_done(enc_done),
      .enc_dout(enc_dout),
      .noise_start(noise_start), .noise_din(noise_din),
      .noise_done(noise_done), .noise_dout(noise_dout),
      .dec_start(dec_start), .dec_din(dec_din), .dec_done(dec_done),
      .dec_dout(dec_dout), .dec_uncorr(dec_uncorr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err),
      .abort(abort), .clr_cnt(clr_cnt), .busy(busy),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt),
      .timeout_flag(timeout_flag)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stage behaviour: done delay (0 = never), noise mask, uncorr flag
   int ed = 1, nd = 1, dd = 1;
   logic [CW-1:0] nmask = 16'h0001;
   logic uncorr = 0;

   function automatic logic [CW-1:0] enc_f(input logic [DW-1:0] x);
      return {x, ~x};
   endfunction
   function automatic logic [DW-1:0] dec_f(input logic [CW-1:0] w);
      return w[15:8];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   // stage cores
   int e_left = 0, n_left = 0, d_left = 0;
   always begin
      @(negedge clk);
      if (rst_n) begin
         if (enc_start) begin e_left = ed; enc_dout = enc_f(enc_din); end
         if (noise_start) begin n_left = nd; noise_dout = noise_din ^ nmask; end
         if (dec_start) begin d_left = dd; dec_dout = dec_f(dec_din); end
      end
      @(posedge clk);
      #1;
      enc_done = 0; noise_done = 0; dec_done = 0;
      dec_uncorr = uncorr;
      if (!rst_n) begin
         e_left = 0; n_left = 0; d_left = 0;
      end else begin
         if (e_left > 0) begin e_left--; enc_done = (e_left == 0); end
         if (n_left > 0) begin n_left--; noise_done = (n_left == 0); end
         if (d_left > 0) begin d_left--; dec_done = (d_left == 0); end
      end
   end

   // model state
   bit m_busy = 0, m_err = 0, m_tmo = 0, m_tf = 0;
   int m_oc = 0, m_es = -1, m_ns = -1, m_ds = -1;
   logic [DW-1:0] m_data = '0;
   logic [1:0] m_mode = '0;
   int m_fc = 0, m_ec = 0;
   int acc_cyc = 0, enc_cyc = -1, noi_cyc = -1, dec_cyc = -1, ov_cyc = -1;
   logic [DW-1:0] last_data = '0;
   logic last_err = 0;

   // a stage lasts its done delay + 1 cycles
   function automatic int stage_len(input int d, output bit to);
      to = 0;
      if (d > 0 && (!TMO_EN || d <= TMO)) return d + 1;
      if (TMO_EN) begin to = 1; return TMO + 1; end
      return 1 << 20;
   endfunction

   task automatic plan(input logic [DW-1:0] d, input logic b,
                       input logic [1:0] mode);
      int c;
      bit to;
      logic [CW-1:0] w;
      c = cyc + 1;
      w = {8'h00, d};
      to = 0;
      m_es = -1; m_ns = -1; m_ds = -1;
      if (b) begin
         m_es = c; c += stage_len(ed, to);
         if (!to) w = enc_f(d);
      end
      if (!to && mode != 2'd0) begin
         m_ns = c; c += stage_len(nd, to);
         if (!to) w = w ^ nmask;
      end
      if (!to && b) begin
         m_ds = c; c += stage_len(dd, to);
      end
      m_oc = c; m_busy = 1; m_mode = mode; m_tmo = to;
      if (to) begin m_data = '0; m_err = 1; end
      else if (b) begin m_data = dec_f(w); m_err = uncorr; end
      else begin m_data = w[7:0]; m_err = 0; end
   endtask

   // compare process
   always @(negedge clk) begin
      bit exp_ov, exp_ir;
      logic [1:0] mi;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_flags", {enc_start, noise_start, dec_start, out_valid,
                           out_err, busy, timeout_flag}, 0);
         chk("rst_cnt", {frame_cnt, err_cnt}, 0);
         chk("rst_data", {noise_mode, out_data}, 0);
         m_busy = 0; m_fc = 0; m_ec = 0; m_tf = 0;
      end else begin
         exp_ov = m_busy && cyc >= m_oc && !abort;
         exp_ir = !m_busy && !abort;
         chk("in_ready", in_ready, exp_ir);
         chk("busy", busy, m_busy);
         chk("enc_start", enc_start, m_busy && cyc == m_es);
         chk("noise_start", noise_start, m_busy && cyc == m_ns);
         chk("dec_start", dec_start, m_busy && cyc == m_ds);
         chk("out_valid", out_valid, exp_ov);
         if (exp_ov) begin
            chk("out_data", out_data, m_data);
            chk("out_err", out_err, m_err);
         end
         if (m_busy) chk("noise_mode", noise_mode, m_mode);
         chk("frame_cnt", frame_cnt, m_fc);
         chk("err_cnt", err_cnt, m_ec);
         chk("timeout_flag", timeout_flag, m_tf);
         if (enc_start) enc_cyc = cyc;
         if (noise_start) noi_cyc = cyc;
         if (dec_start) dec_cyc = cyc;
         if (out_valid && ov_cyc < 0) begin
            ov_cyc = cyc; last_data = out_data; last_err = out_err;
         end
         if (m_busy && m_tmo && cyc + 1 == m_oc && !abort) m_tf = 1;
         if (m_busy && abort) m_busy = 0;
         else if (exp_ov && out_ready) begin
            m_busy = 0;
            if (m_fc != SAT) m_fc++;
            if (m_err && m_ec != SAT) m_ec++;
         end
         if (clr_cnt) begin m_fc = 0; m_ec = 0; m_tf = 0; end
         if (exp_ir && in_valid) begin
            mi = cfg_gauss ? 2'd2 : cfg_ber ? 2'd3 : cfg_fs ? 2'd1 : 2'd0;
            plan(in_data, cfg_bch, mi);
            acc_cyc = cyc;
            enc_cyc = -1; noi_cyc = -1; dec_cyc = -1; ov_cyc = -1;
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic b, fs, g, be);
      bit ok;
      ok = 0;
      in_data = d; cfg_bch = b; cfg_fs = fs; cfg_gauss = g; cfg_ber = be;
      in_valid = 1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send in_ready=%0b want 1 within 50 cycles", in_ready);
      end
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s busy=%0b want 0 within 60 cycles", nm, busy);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk);
      #1;

      // BCH + Gauss, unit latencies
      send(8'hA5, 1, 0, 1, 0);
      wait_idle("t1");
      chk("t1_enc_at", enc_cyc - acc_cyc, 1);
      chk("t1_noise_at", noi_cyc - acc_cyc, 3);
      chk("t1_dec_at", dec_cyc - acc_cyc, 5);
      chk("t1_out_at", ov_cyc - acc_cyc, 7);
      chk("t1_data", last_data, 8'hA5);
      chk("t1_fcnt", frame_cnt, 1);

      // all modes off
      send(8'h3C, 0, 0, 0, 0);
      wait_idle("t2");
      chk("t2_out_at", ov_cyc - acc_cyc, 1);
      chk("t2_nostart", {enc_cyc < 0, noi_cyc < 0, dec_cyc < 0}, 3'b111);
      chk("t2_data", {last_err, last_data}, 9'h03C);

      // uncorrectable, output stalled
      uncorr = 1; out_ready = 0;
      send(8'h5A, 1, 0, 0, 0);
      repeat (15) @(posedge clk);
      #1 out_ready = 1;
      wait_idle("t3");
      uncorr = 0;
      chk("t3_out_at", ov_cyc - acc_cyc, 5);
      chk("t3_data", {last_err, last_data}, 9'h15A);
      chk("t3_cnt", {frame_cnt, err_cnt}, {4'd3, 4'd1});

      // BER beats FS, BCH off, longer noise
      nmask = 16'h0081; nd = 2;
      send(8'hC3, 0, 1, 0, 1);
      wait_idle("t4a");
      chk("t4a_out_at", ov_cyc - acc_cyc, 4);
      chk("t4a_data", last_data, 8'h42);

      // Gauss beats FS, mixed delays
      nmask = 16'h0100; ed = 3; nd = 2; dd = 2;
      send(8'h96, 1, 1, 1, 0);
      wait_idle("t4b");
      chk("t4b_out_at", ov_cyc - acc_cyc, 11);
      chk("t4b_data", last_data, 8'h97);
      ed = 1; nd = 1; dd = 1; nmask = 16'h0001;

      // back-to-back bypass frames to saturation
      cfg_bch = 0; cfg_fs = 0; cfg_gauss = 0; cfg_ber = 0;
      in_data = 8'h01; in_valid = 1;
      repeat (40) @(posedge clk);
      #1 in_valid = 0;
      wait_idle("t5");
      chk("t5_sat", frame_cnt, SAT);

      // clear coincident with an output handshake
      send(8'h02, 0, 0, 0, 0);
      clr_cnt = 1;
      @(posedge clk);
      #1 clr_cnt = 0;
      chk("t5_clr", {frame_cnt, err_cnt}, 0);

      // abort during NOISE
      send(8'h11, 1, 1, 0, 0);
      repeat (3) @(posedge clk);
      #1 abort = 1;
      @(posedge clk);
      #1 abort = 0;
      @(negedge clk);
      chk("t6_idle", busy, 0);
      chk("t6_no_out", ov_cyc, -1);
      chk("t6_fcnt", frame_cnt, 0);

      // abort in IDLE holds off acceptance
      @(posedge clk);
      #1 in_valid = 1; abort = 1;
      @(negedge clk);
      chk("t6_blocked", in_ready, 0);
      @(posedge clk);
      #1 abort = 0;
      @(posedge clk);
      #1 in_valid = 0;
      wait_idle("t6b");
      chk("t6b_fcnt", frame_cnt, 1);

      // reset during DEC
      send(8'h22, 1, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("t7_no_out", ov_cyc, -1);
      chk("t7_cnt", frame_cnt, 0);

`ifdef SEQ_TIMEOUT_EN
      ed = 0;
      send(8'h77, 1, 0, 0, 0);
      wait_idle("t8");
      ed = 1;
      chk("t8_out_at", ov_cyc - acc_cyc, 6);
      chk("t8_data", {last_err, last_data}, 9'h100);
      chk("t8_flag", timeout_flag, 1);
      clr_cnt = 1;
      @(posedge clk);
      #1 clr_cnt = 0;
      chk("t8_clr", timeout_flag, 0);
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
